// File: rtl/alu_ctrl_seq.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU model.
// Drives the memory handshake, register loads and the active-low ALU strobes.
module alu_ctrl_seq #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic       mem_ack,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       addr_sel,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       dr_load,
    output logic       acc_load,
    output logic       acc_src,
    output logic       IADD,
    output logic       ISUB,
    output logic       IAND,
    output logic       IOR,
    output logic       EALU,
    output logic       halted,
    output logic       bus_err,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_OPREAD,
        S_EXEC,
        S_STORE,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_STA = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t           state;
    logic [3:0]       opcode;
    logic [CNT_W-1:0] wait_cnt;
    logic             in_wait;
    logic             op_illegal;

    assign in_wait    = (state == S_FETCH) || (state == S_OPREAD) || (state == S_STORE);
    assign op_illegal = (opcode >= 4'h7) && (opcode <= 4'hE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            opcode   <= '0;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            // Counter is zero whenever a wait state is entered; it only advances while stalled.
            wait_cnt <= '0;
            if (in_wait && !mem_ack) begin
                if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    state   <= S_HALT;
                    bus_err <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end else begin
                case (state)
                    S_FETCH: begin
                        opcode <= instr[7:4];
                        state  <= S_DECODE;
                    end
                    S_DECODE: begin
                        case (opcode)
                            OP_HLT:                                 state <= S_HALT;
                            OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR:  state <= S_OPREAD;
                            OP_STA:                                 state <= S_STORE;
                            default:                                state <= S_FETCH;
                        endcase
                    end
                    S_OPREAD: state <= (opcode == OP_LDA) ? S_FETCH : S_EXEC;
                    S_EXEC:   state <= S_FETCH;
                    S_STORE:  state <= S_FETCH;
                    S_HALT:   state <= S_HALT;
                    default:  state <= S_FETCH;
                endcase
            end
        end
    end

    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        addr_sel = 1'b0;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        dr_load  = 1'b0;
        acc_load = 1'b0;
        acc_src  = 1'b0;
        IADD     = 1'b1;
        ISUB     = 1'b1;
        IAND     = 1'b1;
        IOR      = 1'b1;
        EALU     = 1'b1;
        halted   = 1'b0;
        illegal  = 1'b0;
        case (state)
            S_FETCH: begin
                mem_rd  = 1'b1;
                ir_load = mem_ack;
            end
            S_DECODE: begin
                pc_inc  = 1'b1;
                illegal = op_illegal;
            end
            S_OPREAD: begin
                mem_rd   = 1'b1;
                addr_sel = 1'b1;
                if (mem_ack) begin
                    if (opcode == OP_LDA) acc_load = 1'b1;
                    else                  dr_load  = 1'b1;
                end
            end
            S_EXEC: begin
                IADD     = (opcode != OP_ADD);
                ISUB     = (opcode != OP_SUB);
                IAND     = (opcode != OP_AND);
                IOR      = (opcode != OP_OR);
                EALU     = 1'b0;
                acc_load = 1'b1;
                acc_src  = 1'b1;
            end
            S_STORE: begin
                mem_wr   = 1'b1;
                addr_sel = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule
